// File: rtl/async_counter_dff_if.sv
// Signal bundle grouping clock, reset and count of an async_counter_dff.
// Q is a ripple output; the consuming side samples it on the falling edge of clk.
interface counter_if #(
  parameter int WIDTH = 3
) (
  input logic clk
);
  logic             rst_n;
  logic [WIDTH-1:0] Q;

  modport dut (input clk, input rst_n, output Q);
  modport tb  (input clk, output rst_n, input Q);
endinterface

// File: rtl/async_counter_dff.sv
// Ripple up-counter: chain of toggle DFFs, each later stage clocked by the previous stage's inverted output.
// Q[0] updates one clock-to-Q after rising clk, the MSB settles after up to WIDTH clock-to-Q; no backpressure.
module async_counter_dff_cell (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_q <= 1'b0;
    else          r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

module async_counter_dff #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] Q
);
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_stage_clk;

  assign w_stage_clk[0] = clk;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_stage
      // Rising edge of ~Q[i-1] is the 1->0 fall of the lower bit, i.e. its carry.
      if (i > 0) begin : g_ripple_clk
        assign w_stage_clk[i] = ~w_q[i-1];
      end
      async_counter_dff_cell u_cell (
        .i_clk   (w_stage_clk[i]),
        .i_rst_n (rst_n),
        .i_d     (~w_q[i]),
        .o_q     (w_q[i])
      );
    end
  endgenerate

  assign Q = w_q;
endmodule

// File: tb/tb_async_counter_dff.sv
// Bench for async_counter_dff at WIDTH 3 and 4, sampling Q on falling clk against an edge-counting model.
module tb_async_counter_dff;
  logic       clk;
  logic       rst_n;
  logic [2:0] q3;
  logic [3:0] q4;

  int checks   = 0;
  int failures = 0;

  // Reference: number of rising edges seen since last reset, modulo 2^WIDTH.
  int edges_since_reset = 0;
  int exp3;
  int exp4;

  async_counter_dff #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .Q(q3));
  async_counter_dff #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .Q(q4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge rst_n) edges_since_reset = 0;
  always @(posedge clk) if (rst_n === 1'b1) edges_since_reset = edges_since_reset + 1;
  always_comb begin
    exp3 = edges_since_reset % 8;
    exp4 = edges_since_reset % 16;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_both(input string name);
    checks++;
    if (q3 !== exp3[2:0]) begin
      failures++;
      $display("FAIL %s w3: got %0d expected %0d at %0t", name, q3, exp3, $time);
    end
    checks++;
    if (q4 !== exp4[3:0]) begin
      failures++;
      $display("FAIL %s w4: got %0d expected %0d at %0t", name, q4, exp4, $time);
    end
  endtask

  // Mid-cycle pulse: starts 1-2 ns after a falling edge, released before the next rising edge.
  task automatic reset_pulse();
    @(negedge clk);
    #($urandom_range(1, 2));
    rst_n = 1'b0;
    #1;
    checks++;
    if (q3 !== 3'd0 || q4 !== 4'd0) begin
      failures++;
      $display("FAIL reset_pulse: got q3=%0d q4=%0d expected 0", q3, q4);
    end
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (q3 !== 3'd0 || q4 !== 4'd0) begin
        failures++;
        $display("FAIL reset_hold: got q3=%0d q4=%0d expected 0", q3, q4);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_count();
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check_both("count");
      checks++;
      if (q3 !== k[2:0]) begin
        failures++;
        $display("FAIL count_seq: got %0d expected %0d", q3, k % 8);
      end
    end
    checks++;
    if (q3 !== 3'b010 || $time != 120) begin
      failures++;
      $display("FAIL count_at_120ns: got %b at %0t expected 010 at 120", q3, $time);
    end
  endtask

  task automatic test_wrap();
    logic [2:0] want;
    reset_pulse();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      want = k[2:0];
      checks++;
      if (q3 !== want) begin
        failures++;
        $display("FAIL wrap step %0d: got %b expected %b", k, q3, want);
      end
    end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    reset_pulse();
    while (exp3 != 5 && guard < 16) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (q3 !== 3'b101) begin
      failures++;
      $display("FAIL async_reset_setup: got %b expected 101 (waited %0d)", q3, guard);
    end
    #2;
    rst_n = 1'b0;
    #0.5;
    checks++;
    if (q3 !== 3'd0 || q4 !== 4'd0) begin
      failures++;
      $display("FAIL async_reset_immediate: got q3=%0d q4=%0d expected 0", q3, q4);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (q3 !== 3'd0 || q4 !== 4'd0) begin
        failures++;
        $display("FAIL async_reset_hold: got q3=%0d q4=%0d expected 0", q3, q4);
      end
    end
  endtask

  task automatic test_resume();
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (q3 !== 3'd1 || q4 !== 4'd1) begin
      failures++;
      $display("FAIL resume: got q3=%0d q4=%0d expected 1", q3, q4);
    end
  endtask

  task automatic test_width4();
    logic [3:0] want;
    reset_pulse();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      want = k[3:0];
      checks++;
      if (q4 !== want) begin
        failures++;
        $display("FAIL width4 step %0d: got %0d expected %0d", k, q4, want);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) == 0) reset_pulse();
      repeat ($urandom_range(1, 20)) begin
        @(negedge clk);
        check_both("random");
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_count();
    test_wrap();
    test_async_reset();
    test_resume();
    test_width4();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
